instr_sequencer: RTL
====================

Name: instr_sequencer

Overview:
- Instruction-side counterpart of the control unit. Owns the instruction pointer (IP) and fetches instruction words from program memory over a req/valid handshake.
- Splits each word into command_group/command/operand fields for the control unit.
- Consumes the control unit's branch_select and is_atc, plus the ALU condition, to compute the next IP.
- Runs the multi-cycle atomic test-and-clear (ATC) handshake with the flag register.

Parameters:
- INSTR_WIDTH, 32, instruction word width; fixed field map below, minimum 24.
- ADDR_WIDTH, 8, IP/program address width; IP wraps modulo 2^ADDR_WIDTH.
- RESET_VECTOR, 0, IP value loaded on reset.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- run  in  1  level; allows new fetches.
- instr_req  out  1  fetch request.
- instr_addr  out  ADDR_WIDTH  fetch address (= IP).
- instr_valid  in  1  instr_data valid this cycle.
- instr_data  in  INSTR_WIDTH  fetched word.
- command_group  out  3  ir[INSTR_WIDTH-1 -: 3].
- command  out  3  ir[INSTR_WIDTH-4 -: 3].
- operand_a  out  8  ir[15:8]; also ATC flag index.
- operand_b  out  8  ir[7:0]; jump target is operand_b[ADDR_WIDTH-1:0] zero-extended.
- exec_valid  out  1  high exactly during the EXECUTE cycle; qualifies downstream write_enable.
- branch_select  in  1  from control unit.
- is_atc  in  1  from control unit.
- cond_true  in  1  ALU condition result.
- atc_req  out  1  ATC request to flag register.
- atc_index  out  8  flag index (= operand_a).
- atc_ack  in  1  flag tested and cleared this cycle.
- atc_was_set  in  1  prior flag value; valid with atc_ack.
- ip  out  ADDR_WIDTH  current IP, for debug.

Behaviour:
- States: IDLE, FETCH, EXECUTE, ATC_WAIT.
- Reset values: state=IDLE, ip=RESET_VECTOR, ir=0 (decodes as NOP), instr_req=0, exec_valid=0, atc_req=0.
- A reset asserted in any state overrides all other inputs at that edge. An outstanding fetch or ATC request is abandoned, and instr_req/atc_req are low from the next cycle.
- IDLE: when run=1, go to FETCH the next cycle.
- FETCH:
  - instr_req=1 and instr_addr=ip, both registered and held stable until instr_valid.
  - On the edge where instr_valid=1: ir <= instr_data, go to EXECUTE.
  - Minimum fetch latency is 1 cycle after the request; wait is unbounded.
- instr_valid is ignored outside FETCH.
- EXECUTE (exactly one cycle, exec_valid=1); priority order:
  - is_atc=1: go to ATC_WAIT; ip unchanged.
  - Else branch_select=1 and cond_true=1: ip <= jump target.
  - Else: ip <= ip+1, wrapping from all-ones to 0.
  - Next state after a non-ATC instruction: FETCH if run=1, else IDLE.
- ATC_WAIT:
  - atc_req=1 and atc_index=operand_a, held until atc_ack.
  - On atc_ack: ip <= target if atc_was_set=1, else ip+1.
  - atc_req drops the following cycle. Next state as for EXECUTE.
  - cond_true and branch_select are ignored in this state.
- command_group, command and operands are driven from ir and stay stable from EXECUTE until the next instr_valid.
- Deasserting run mid-instruction completes the instruction, then the sequencer parks in IDLE with ip pointing at the next instruction.
- Throughput: 3 cycles per instruction with zero-wait memory; ATC adds at least 1 cycle.

Optional Feature:
- Macro: SEQ_SINGLE_STEP_EN.
- When defined: adds input step (1-bit pulse). IDLE→FETCH requires run=1 and step=1 in the same cycle. After each instruction the sequencer returns to IDLE regardless of run.
- When undefined: no step port, behaviour exactly as above.

Test Plan:
- Reset → ip=RESET_VECTOR=0, instr_req=0; hold reset with run=1 → stays IDLE. Release → FETCH with instr_addr=0 one cycle later.
- Three NOPs from addr 0 with zero-wait memory → instr_addr sequence 0,1,2, exec_valid pulse every 3rd cycle.
- JMP at addr 5 with target 0x20:
  - branch_select=1, cond_true=1 → next instr_addr=0x20.
  - cond_true=0 → next instr_addr=6.
- ATC at addr 3, index 7, atc_ack after 4 cycles:
  - atc_req high exactly until ack, atc_index=7.
  - atc_was_set=1 → target; atc_was_set=0 → 4.
- NOP at ip=0xFF (ADDR_WIDTH=8) → next ip=0x00. Assert reset during FETCH wait → instr_req=0 next cycle, ip=0, a late instr_valid is ignored.
- run dropped during EXECUTE at ip=10 → IDLE with ip=11 and no instr_req. With SEQ_SINGLE_STEP_EN: one step pulse → exactly one exec_valid pulse.

Source files
------------

// File: rtl/instr_sequencer.sv
// ---------------------------------------------------------------------------
// instr_sequencer
//
// Instruction-side sequencer. Owns the instruction pointer, fetches words from
// program memory over a req/valid handshake, splits the instruction register
// into command/operand fields, resolves the next IP from the control unit's
// branch decision, and runs the atomic test-and-clear (ATC) handshake with the
// flag register.
//
// Optional feature macro: SEQ_SINGLE_STEP_EN
//   When defined, an extra 'step' input gates IDLE->FETCH (run and step must
//   both be high), and the sequencer parks in IDLE after every instruction.
//
// Ports:
//   clock, reset      rising-edge clock, synchronous active-high reset
//   run               level enable for new fetches
//   step              (SEQ_SINGLE_STEP_EN only) single-step pulse
//   instr_req/addr    registered fetch request and address (= ip)
//   instr_valid/data  fetched word, accepted only while fetching
//   command_group     ir[INSTR_WIDTH-1 -: 3]
//   command           ir[INSTR_WIDTH-4 -: 3]
//   operand_a/b       ir[15:8] / ir[7:0]; operand_b is the jump target
//   exec_valid        high during the single EXECUTE cycle
//   branch_select     control unit wants a conditional jump
//   is_atc            control unit flags an ATC instruction
//   cond_true         ALU condition
//   atc_req/index     ATC request to the flag register, index = operand_a
//   atc_ack/was_set   flag tested and cleared, with its prior value
//   ip                current instruction pointer (debug)
// ---------------------------------------------------------------------------
module instr_sequencer #(
    parameter int                    INSTR_WIDTH  = 32,
    parameter int                    ADDR_WIDTH   = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   run,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic                   step,
`endif
    output logic                   instr_req,
    output logic [ADDR_WIDTH-1:0]  instr_addr,
    input  logic                   instr_valid,
    input  logic [INSTR_WIDTH-1:0] instr_data,
    output logic [2:0]             command_group,
    output logic [2:0]             command,
    output logic [7:0]             operand_a,
    output logic [7:0]             operand_b,
    output logic                   exec_valid,
    input  logic                   branch_select,
    input  logic                   is_atc,
    input  logic                   cond_true,
    output logic                   atc_req,
    output logic [7:0]             atc_index,
    input  logic                   atc_ack,
    input  logic                   atc_was_set,
    output logic [ADDR_WIDTH-1:0]  ip
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] FETCH    = 2'd1;
    localparam logic [1:0] EXECUTE  = 2'd2;
    localparam logic [1:0] ATC_WAIT = 2'd3;

    logic [1:0]             r_state;
    logic [ADDR_WIDTH-1:0]  r_ip;
    logic [INSTR_WIDTH-1:0] r_ir;
    logic                   r_instrReq;
    logic                   r_execValid;
    logic                   r_atcReq;

    logic [1:0]             w_nextState;
    logic [ADDR_WIDTH-1:0]  w_nextIp;
    logic [ADDR_WIDTH-1:0]  w_target;
    logic [ADDR_WIDTH-1:0]  w_ipPlusOne;
    logic [1:0]             w_afterInstr;
    logic                   w_startFetch;
    logic                   w_unusedIrBits;

    // The jump target is operand_b resized to the address width; the cast
    // zero-extends for wide address spaces and truncates for narrow ones.
    assign w_target    = ADDR_WIDTH'(r_ir[7:0]);
    assign w_ipPlusOne = r_ip + ADDR_WIDTH'(1);

    // Single-step mode needs an explicit step pulse to leave IDLE and always
    // returns to IDLE, so each pulse yields exactly one instruction.
`ifdef SEQ_SINGLE_STEP_EN
    assign w_startFetch = run && step;
    assign w_afterInstr = IDLE;
`else
    assign w_startFetch = run;
    assign w_afterInstr = run ? FETCH : IDLE;
`endif

    // Next-state and next-IP selection. The IP only moves when an instruction
    // retires (end of EXECUTE, or ATC acknowledge), so it stays stable as the
    // fetch address throughout FETCH. An ATC takes priority over any branch
    // decision, and while waiting for the acknowledge the branch inputs are
    // deliberately not looked at.
    always_comb begin
        w_nextState = r_state;
        w_nextIp    = r_ip;
        case (r_state)
            IDLE: begin
                if (w_startFetch) begin
                    w_nextState = FETCH;
                end
            end
            FETCH: begin
                if (instr_valid) begin
                    w_nextState = EXECUTE;
                end
            end
            EXECUTE: begin
                if (is_atc) begin
                    w_nextState = ATC_WAIT;
                end else begin
                    w_nextState = w_afterInstr;
                    w_nextIp    = (branch_select && cond_true) ? w_target : w_ipPlusOne;
                end
            end
            ATC_WAIT: begin
                if (atc_ack) begin
                    w_nextState = w_afterInstr;
                    w_nextIp    = atc_was_set ? w_target : w_ipPlusOne;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // State, IP and instruction register. The handshake outputs are
    // registered copies of "next state is X", so they rise on entry to the
    // state and fall the cycle after leaving it, glitch-free. Reset wins over
    // everything, abandoning any outstanding fetch or ATC request.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_ip        <= RESET_VECTOR;
            r_ir        <= '0;
            r_instrReq  <= 1'b0;
            r_execValid <= 1'b0;
            r_atcReq    <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_ip        <= w_nextIp;
            if (r_state == FETCH && instr_valid) begin
                r_ir <= instr_data;
            end
            r_instrReq  <= (w_nextState == FETCH);
            r_execValid <= (w_nextState == EXECUTE);
            r_atcReq    <= (w_nextState == ATC_WAIT);
        end
    end

    // The middle bits of the word belong to no field; they are kept in the
    // register only so that ir mirrors the fetched word exactly.
    assign w_unusedIrBits = ^r_ir[INSTR_WIDTH-7:16];

    assign instr_req     = r_instrReq;
    assign instr_addr    = r_ip;
    assign ip            = r_ip;
    assign exec_valid    = r_execValid;
    assign atc_req       = r_atcReq;
    assign command_group = r_ir[INSTR_WIDTH-1 -: 3];
    assign command       = r_ir[INSTR_WIDTH-4 -: 3];
    assign operand_a     = r_ir[15:8];
    assign operand_b     = r_ir[7:0];
    assign atc_index     = r_ir[15:8];

endmodule
